ram64_fifo_ctrl: RTL and testbench
==================================

// Module: ram64_fifo_ctrl
// PURPOSE
//   Upstream controller that turns a RAM64 (64 x 16, single address port, write on clk edge
//   when load=1, combinational read of word at address) into a 16-bit valid/ready FIFO.
//   Drives RAM64 in/load/address, captures RAM64 out into a registered pop stage.
//   One RAM access per cycle (write or read), arbitrated between push and prefetch.
// PARAMETERS
//   WIDTH      16  data width; must match RAM64 word width
//   AW         6   RAM address width; RAM depth = 2**AW = 64
// PORTS
//   clk          in   1      rising-edge clock, shared with RAM64
//   reset        in   1      asynchronous, active-high reset
//   push_valid   in   1      upstream offers push_data
//   push_ready   out  1      push accepted this cycle when push_valid & push_ready
//   push_data    in   WIDTH  word to store
//   pop_valid    out  1      pop_data holds the oldest word
//   pop_ready    in   1      downstream takes pop_data when pop_valid & pop_ready
//   pop_data     out  WIDTH  registered head-of-FIFO word
//   count        out  7      RAM occupancy + pop stage, 0..65
//   full         out  1      RAM occupancy == 64
//   empty        out  1      count == 0
//   ram_in       out  WIDTH  to RAM64 in (= push_data)
//   ram_load     out  1      to RAM64 load
//   ram_address  out  AW     to RAM64 address
//   ram_out      in   WIDTH  from RAM64 out
// BEHAVIOUR
//   State: wr_ptr[5:0], rd_ptr[5:0], ram_cnt[6:0] (0..64), pop_valid, pop_data, prio (0=write-first).
//   Reset (async): wr_ptr=rd_ptr=0, ram_cnt=0, pop_valid=0, pop_data=0, prio=0; ram_load=0 while reset=1.
//   Per cycle, combinational requests:
//     want_wr = push_valid & (ram_cnt != 64)
//     want_rd = (ram_cnt != 0) & (~pop_valid | pop_ready)
//   Grant: only one -> grant it; both -> grant write if prio=0 else read, then prio toggles
//   (prio changes only on contention cycles); none -> idle.
//   Write grant: push_ready=1, ram_load=1, ram_address=wr_ptr, ram_in=push_data;
//     at edge wr_ptr+=1 (wraps 63->0), ram_cnt+=1.
//   Read grant: ram_load=0, ram_address=rd_ptr; at edge pop_data<=ram_out, pop_valid<=1,
//     rd_ptr+=1 (wraps 63->0), ram_cnt-=1. Read latency: word reaches pop_data 1 edge after grant.
//   Idle/no write: push_ready=0, ram_load=0, ram_address=rd_ptr.
//   push_ready may depend on push_valid; push_valid must not depend on push_ready.
//   Pop: pop_valid & pop_ready with no read grant -> pop_valid<=0 at edge; with read grant ->
//     pop_data replaced, pop_valid stays 1 (back-to-back).
//   pop_data/pop_valid held stable while pop_valid & ~pop_ready.
//   Never write and read RAM same cycle; a word written at edge N is readable from cycle N+1.
//   count = ram_cnt + pop_valid; full = (ram_cnt==64); empty = (count==0).
//   full: push_ready=0 regardless of pop activity that cycle (freed slot usable next cycle).
//   empty RAM: no read grant; pop_ready ignored when pop_valid=0.
//   Reset mid-operation: all stored words discarded, pop_valid drops immediately; RAM contents
//     not cleared but unreachable.
// TESTING
//   1 reset, push 0x0001 for one cycle, pop_ready=0 -> cyc0 ram_load=1 addr=0; cyc1 read
//     addr=0; after cyc1 edge pop_valid=1 pop_data=0x0001, count=1, ram_cnt=0.
//   2 push 0x0100..0x0140 (65 words), pop_ready=0 -> 65 accepted, then push_ready=0,
//     full=1, count=65; pop all -> 0x0100..0x0140 in order, empty=1 at end.
//   3 push_valid and pop_ready held 1, 130 words streamed -> order preserved, pointers wrap
//     63->0 twice, grants alternate W/R on contention cycles, no loss or duplication.
//   4 full FIFO, pop_ready=1 & push_valid=1 -> cycle 1 read granted only (want_wr=0);
//     write accepted in following cycle, count returns to 65.
//   5 10 words stored, assert reset mid-cycle -> pop_valid=0, count=0, empty=1 without a clk
//     edge; after release, new pushes pop first, old data never appears.
//   6 empty FIFO, pop_ready=1, no push for 20 cycles -> pop_valid=0, ram_load=0 throughout.

Source files
------------

// File: rtl/ram64_fifo_ctrl.sv
// Valid/ready FIFO built on an external single-port RAM64 (64 x 16, sync write, comb read).
// One RAM access per cycle, arbitrated between push writes and pop-stage prefetch reads.
module ram64_fifo_ctrl #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned AW    = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_valid,
  output logic             push_ready,
  input  logic [WIDTH-1:0] push_data,
  output logic             pop_valid,
  input  logic             pop_ready,
  output logic [WIDTH-1:0] pop_data,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] ram_in,
  output logic             ram_load,
  output logic [AW-1:0]    ram_address,
  input  logic [WIDTH-1:0] ram_out
);

  localparam int unsigned DEPTH = 2 ** AW;
  localparam int unsigned CW    = AW + 1;

  typedef enum logic {
    PRIO_WR = 1'b0,
    PRIO_RD = 1'b1
  } prio_t;

  prio_t           prio_q;
  prio_t           prio_d;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   ram_cnt;
  logic            want_wr;
  logic            want_rd;
  logic            grant_wr;
  logic            grant_rd;

  // Arbitration: a lone request wins; on contention prio picks and then flips.
  always_comb begin
    prio_d      = prio_q;
    want_wr     = 1'b0;
    want_rd     = 1'b0;
    grant_wr    = 1'b0;
    grant_rd    = 1'b0;
    push_ready  = 1'b0;
    ram_load    = 1'b0;
    ram_in      = push_data;
    ram_address = rd_ptr;

    want_wr  = push_valid && (ram_cnt != CW'(DEPTH)) && !reset;
    want_rd  = (ram_cnt != '0) && (!pop_valid || pop_ready);
    grant_wr = want_wr && (!want_rd || (prio_q == PRIO_WR));
    grant_rd = want_rd && !grant_wr;

    if (want_wr && want_rd) begin
      prio_d = (prio_q == PRIO_WR) ? PRIO_RD : PRIO_WR;
    end

    if (grant_wr) begin
      push_ready  = 1'b1;
      ram_load    = 1'b1;
      ram_address = wr_ptr;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prio_q    <= PRIO_WR;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      ram_cnt   <= '0;
      pop_valid <= 1'b0;
      pop_data  <= '0;
    end else begin
      prio_q <= prio_d;
      if (grant_wr) begin
        wr_ptr  <= wr_ptr + AW'(1);
        ram_cnt <= ram_cnt + CW'(1);
      end else if (grant_rd) begin
        rd_ptr  <= rd_ptr + AW'(1);
        ram_cnt <= ram_cnt - CW'(1);
      end
      // A prefetch read refills the pop stage even while it is being drained.
      if (grant_rd) begin
        pop_data  <= ram_out;
        pop_valid <= 1'b1;
      end else if (pop_valid && pop_ready) begin
        pop_valid <= 1'b0;
      end
    end
  end

  assign count = ram_cnt + CW'(pop_valid);
  assign full  = (ram_cnt == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: tb/tb_ram64_fifo_ctrl.sv
// Bench for ram64_fifo_ctrl: behavioural RAM64 model plus an in-order scoreboard
// fed on accepted pushes and checked on accepted pops.
module tb_ram64_fifo_ctrl;

  logic        clk;
  logic        reset;
  logic        push_valid;
  logic        push_ready;
  logic [15:0] push_data;
  logic        pop_valid;
  logic        pop_ready;
  logic [15:0] pop_data;
  logic [6:0]  count;
  logic        full;
  logic        empty;
  logic [15:0] ram_in;
  logic        ram_load;
  logic [5:0]  ram_address;
  logic [15:0] ram_out;

  logic [15:0] mem [64];
  logic [15:0] exp_q [$];
  int          n_chk = 0;
  int          n_err = 0;
  int          pop_cnt = 0;
  int          alt_err = 0;
  int          stream_cyc = 0;
  logic        stream_on = 1'b0;
  logic        prev_load = 1'b0;

  ram64_fifo_ctrl #(.WIDTH(16), .AW(6)) dut (
    .clk(clk), .reset(reset),
    .push_valid(push_valid), .push_ready(push_ready), .push_data(push_data),
    .pop_valid(pop_valid), .pop_ready(pop_ready), .pop_data(pop_data),
    .count(count), .full(full), .empty(empty),
    .ram_in(ram_in), .ram_load(ram_load), .ram_address(ram_address), .ram_out(ram_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_load) mem[ram_address] <= ram_in;
  end
  assign ram_out = mem[ram_address];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Handshakes are sampled at the falling edge, where inputs are already stable.
  always @(negedge clk) begin
    logic [31:0] e;
    if (!reset) begin
      if (pop_valid && pop_ready) begin
        e = (exp_q.size() > 0) ? 32'(exp_q.pop_front()) : 32'hFFFF_FFFF;
        check("pop_data", 32'(pop_data), e);
        pop_cnt++;
      end
      if (push_valid && push_ready) exp_q.push_back(push_data);
      if (stream_on) begin
        if (stream_cyc >= 5 && ram_load == prev_load) alt_err++;
        prev_load = ram_load;
        stream_cyc++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [15:0] base, input int n);
    int idx = 0;
    int c = 0;
    while (idx < n && c < 1000) begin
      push_valid = 1'b1;
      push_data  = base + 16'(idx);
      @(negedge clk);
      if (push_ready) idx++;
      step();
      c++;
    end
    push_valid = 1'b0;
    check("fill_accepted", 32'(idx), 32'(n));
  endtask

  task automatic drain(input int max_cyc);
    int c = 0;
    pop_ready = 1'b1;
    while (!empty && c < max_cyc) begin
      step();
      c++;
    end
    pop_ready = 1'b0;
    check("drain_empty", 32'(empty), 32'd1);
    check("sb_left", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int p0;
    reset      = 1'b1;
    push_valid = 1'b1;
    push_data  = 16'hAAAA;
    pop_ready  = 1'b1;
    #2;
    check("rst_ram_load", 32'(ram_load), 32'd0);
    check("rst_pop_valid", 32'(pop_valid), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset      = 1'b0;
    push_valid = 1'b0;
    pop_ready  = 1'b0;
    step();

    // Single word: write cycle, then prefetch read into the pop stage.
    push_valid = 1'b1;
    push_data  = 16'h0001;
    @(negedge clk);
    check("t1_wr_load", 32'(ram_load), 32'd1);
    check("t1_wr_addr", 32'(ram_address), 32'd0);
    check("t1_push_ready", 32'(push_ready), 32'd1);
    step();
    push_valid = 1'b0;
    @(negedge clk);
    check("t1_rd_load", 32'(ram_load), 32'd0);
    check("t1_rd_addr", 32'(ram_address), 32'd0);
    step();
    check("t1_pop_valid", 32'(pop_valid), 32'd1);
    check("t1_pop_data", 32'(pop_data), 32'h0001);
    check("t1_count", 32'(count), 32'd1);
    drain(10);

    // Fill to capacity, confirm backpressure, then drain in order.
    fill(16'h0100, 65);
    push_valid = 1'b1;
    push_data  = 16'h0141;
    @(negedge clk);
    check("t2_push_ready", 32'(push_ready), 32'd0);
    check("t2_full", 32'(full), 32'd1);
    check("t2_count", 32'(count), 32'd65);
    check("t2_ram_load", 32'(ram_load), 32'd0);
    step();
    push_valid = 1'b0;
    drain(300);

    // Continuous streaming across two pointer wraps.
    p0         = pop_cnt;
    pop_ready  = 1'b1;
    stream_cyc = 0;
    stream_on  = 1'b1;
    fill(16'h1000, 130);
    stream_on  = 1'b0;
    check("t3_alternate", 32'(alt_err), 32'd0);
    drain(300);
    check("t3_pop_total", 32'(pop_cnt - p0), 32'd130);

    // Full FIFO with simultaneous pop and push: read first, write next cycle.
    fill(16'h0200, 65);
    check("t4_count_full", 32'(count), 32'd65);
    push_valid = 1'b1;
    push_data  = 16'h0300;
    pop_ready  = 1'b1;
    @(negedge clk);
    check("t4_c1_push_ready", 32'(push_ready), 32'd0);
    check("t4_c1_ram_load", 32'(ram_load), 32'd0);
    step();
    pop_ready = 1'b0;
    @(negedge clk);
    check("t4_c2_push_ready", 32'(push_ready), 32'd1);
    check("t4_c2_ram_load", 32'(ram_load), 32'd1);
    step();
    push_valid = 1'b0;
    check("t4_count", 32'(count), 32'd65);
    check("t4_full", 32'(full), 32'd1);
    drain(300);

    // Asynchronous reset mid-cycle discards stored words.
    fill(16'h0400, 10);
    check("t5_pre_pop_valid", 32'(pop_valid), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("t5_pop_valid", 32'(pop_valid), 32'd0);
    check("t5_count", 32'(count), 32'd0);
    check("t5_empty", 32'(empty), 32'd1);
    exp_q.delete();
    #3;
    reset = 1'b0;
    step();
    p0 = pop_cnt;
    fill(16'h0500, 3);
    drain(20);
    check("t5_pop_total", 32'(pop_cnt - p0), 32'd3);

    // Empty FIFO with pop_ready high: nothing moves.
    pop_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("t6_pop_valid", 32'(pop_valid), 32'd0);
      check("t6_ram_load", 32'(ram_load), 32'd0);
      step();
    end
    pop_ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
